// File: rtl/debounce_multi.sv
// N-channel switch debouncer with selectable LOCKOUT/STABLE filter and optional
// 2-flop input synchroniser. Every channel runs its own filter and counter.
module debounce_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DELAY_CNT = 3,
  parameter int unsigned MODE      = 0,
  parameter int unsigned SYNC_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  localparam int unsigned CW = ($clog2(DELAY_CNT + 1) < 1) ? 1 : $clog2(DELAY_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DELAY_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [CHANNELS-1:0] s;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [CHANNELS-1:0] sync_q1;
      logic [CHANNELS-1:0] sync_q2;

      // Two-flop synchroniser on every raw switch bit
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q1 <= '0;
          sync_q2 <= '0;
        end else begin
          sync_q1 <= sw;
          sync_q2 <= sync_q1;
        end
      end

      assign s = sync_q2;
    end else begin : g_nosync
      assign s = sw;
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      state_t        state, state_n;
      logic [CW-1:0] cnt, cnt_n;
      logic          out_q, out_n;
      logic          rise_q, fall_q, busy_q, busy_n;

      // Next-state logic: lockout FSM in MODE 0, stability counter in MODE 1
      always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out_q;
        busy_n  = 1'b0;
        if (MODE == 0) begin
          case (state)
            IDLE: begin
              if (s[i] != out_q) begin
                out_n   = s[i];
                cnt_n   = CNT_MAX;
                state_n = HOLD;
              end
            end
            HOLD: begin
              if (cnt == '0) begin
                state_n = IDLE;
              end else begin
                cnt_n = cnt - CNT_ONE;
              end
            end
            default: state_n = IDLE;
          endcase
          busy_n = (state_n == HOLD);
        end else begin
          if (s[i] == out_q) begin
            cnt_n = '0;
          end else if (cnt == CNT_MAX) begin
            out_n = s[i];
            cnt_n = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
          busy_n = (cnt_n != '0);
        end
      end

      // Channel registers; edge pulses are registered alongside the level
      always_ff @(posedge clk) begin
        if (rst) begin
          state  <= IDLE;
          cnt    <= '0;
          out_q  <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          busy_q <= 1'b0;
        end else begin
          state  <= state_n;
          cnt    <= cnt_n;
          out_q  <= out_n;
          rise_q <= out_n & ~out_q;
          fall_q <= ~out_n & out_q;
          busy_q <= busy_n;
        end
      end

      assign out[i]  = out_q;
      assign rise[i] = rise_q;
      assign fall[i] = fall_q;
      assign busy[i] = busy_q;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: four instances (LOCKOUT/STABLE x sync off/on) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_debounce_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned NC = 4;  // config c: mode = c%2, sync = c/2

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] sw;
  logic [CH-1:0] out_v  [NC];
  logic [CH-1:0] rise_v [NC];
  logic [CH-1:0] fall_v [NC];
  logic [CH-1:0] busy_v [NC];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_multi #(.CHANNELS(CH), .DELAY_CNT(D), .MODE(0), .SYNC_EN(0)) u_m0s0 (
    .clk(clk), .rst(rst), .sw(sw),
    .out(out_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .busy(busy_v[0]));
  debounce_multi #(.CHANNELS(CH), .DELAY_CNT(D), .MODE(1), .SYNC_EN(0)) u_m1s0 (
    .clk(clk), .rst(rst), .sw(sw),
    .out(out_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .busy(busy_v[1]));
  debounce_multi #(.CHANNELS(CH), .DELAY_CNT(D), .MODE(0), .SYNC_EN(1)) u_m0s1 (
    .clk(clk), .rst(rst), .sw(sw),
    .out(out_v[2]), .rise(rise_v[2]), .fall(fall_v[2]), .busy(busy_v[2]));
  debounce_multi #(.CHANNELS(CH), .DELAY_CNT(D), .MODE(1), .SYNC_EN(1)) u_m1s1 (
    .clk(clk), .rst(rst), .sw(sw),
    .out(out_v[3]), .rise(rise_v[3]), .fall(fall_v[3]), .busy(busy_v[3]));

  // Reference model state
  logic [CH-1:0] m_out  [NC];
  logic [CH-1:0] m_rise [NC];
  logic [CH-1:0] m_fall [NC];
  logic [CH-1:0] m_busy [NC];
  logic [CH-1:0] m_s1   [NC];
  logic [CH-1:0] m_s2   [NC];
  int            lock_left [NC][CH];  // remaining lockout cycles (MODE 0)
  logic [D:0]    hist      [NC][CH];  // last D+1 filtered samples (MODE 1)

  // Advance the model by one clock edge given the inputs seen at that edge
  task automatic model_step(input logic [CH-1:0] swv, input logic rstv);
    for (int c = 0; c < NC; c++) begin
      logic [CH-1:0] s;
      logic [CH-1:0] old;
      s   = (c / 2 == 1) ? m_s2[c] : swv;
      old = m_out[c];
      if (rstv) begin
        m_out[c]  = '0;
        m_rise[c] = '0;
        m_fall[c] = '0;
        m_busy[c] = '0;
        m_s1[c]   = '0;
        m_s2[c]   = '0;
        for (int k = 0; k < CH; k++) begin
          lock_left[c][k] = 0;
          hist[c][k]      = '0;
        end
      end else begin
        m_s2[c] = m_s1[c];
        m_s1[c] = swv;
        for (int k = 0; k < CH; k++) begin
          if (c % 2 == 0) begin
            // Lockout: take a differing input at once, then ignore D+1 cycles
            if (lock_left[c][k] > 0) begin
              lock_left[c][k]--;
            end else if (s[k] != old[k]) begin
              m_out[c][k]     = s[k];
              lock_left[c][k] = D + 1;
            end
            m_busy[c][k] = (lock_left[c][k] > 0);
          end else begin
            // Stable: flip once the last D+1 samples all disagree with out
            hist[c][k] = {hist[c][k][D-1:0], s[k]};
            if (hist[c][k] == {(D+1){~old[k]}}) begin
              m_out[c][k]  = ~old[k];
              m_busy[c][k] = 1'b0;
            end else begin
              m_busy[c][k] = (s[k] != old[k]);
            end
          end
        end
        m_rise[c] = m_out[c] & ~old;
        m_fall[c] = ~m_out[c] & old;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NC; c++) begin
      n_checks++;
      assert (out_v[c] === m_out[c]) else begin
        n_fail++;
        $error("FAIL %s out cfg%0d: got %h expected %h t=%0t", tag, c, out_v[c], m_out[c], $time);
      end
      n_checks++;
      assert (rise_v[c] === m_rise[c]) else begin
        n_fail++;
        $error("FAIL %s rise cfg%0d: got %h expected %h t=%0t", tag, c, rise_v[c], m_rise[c], $time);
      end
      n_checks++;
      assert (fall_v[c] === m_fall[c]) else begin
        n_fail++;
        $error("FAIL %s fall cfg%0d: got %h expected %h t=%0t", tag, c, fall_v[c], m_fall[c], $time);
      end
      n_checks++;
      assert (busy_v[c] === m_busy[c]) else begin
        n_fail++;
        $error("FAIL %s busy cfg%0d: got %h expected %h t=%0t", tag, c, busy_v[c], m_busy[c], $time);
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update model, compare after the edge
  task automatic step(input logic [CH-1:0] v, input logic r, input string tag);
    sw  = v;
    rst = r;
    @(posedge clk);
    model_step(v, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [CH-1:0] cur;
    logic [CH-1:0] mask;
    int            p;

    sw  = '0;
    rst = 1'b1;
    for (int c = 0; c < NC; c++) begin
      m_out[c] = '0; m_rise[c] = '0; m_fall[c] = '0; m_busy[c] = '0;
      m_s1[c] = '0;  m_s2[c] = '0;
      for (int k = 0; k < CH; k++) begin
        lock_left[c][k] = 0;
        hist[c][k]      = '0;
      end
    end
    @(negedge clk);

    // Reset held with all switches high, then release
    step(4'hF, 1'b1, "reset1");
    step(4'hF, 1'b1, "reset2");
    for (int n = 0; n < 10; n++) step(4'hF, 1'b0, "release");
    for (int n = 0; n < 10; n++) step(4'h0, 1'b0, "all_low");

    // ch0 bounces right after its first edge
    step(4'h1, 1'b0, "bounce0");
    step(4'h0, 1'b0, "bounce0");
    step(4'h1, 1'b0, "bounce0");
    step(4'h0, 1'b0, "bounce0");
    for (int n = 0; n < 8; n++) step(4'h1, 1'b0, "bounce0_hold");
    for (int n = 0; n < 10; n++) step(4'h0, 1'b0, "settle");

    // ch1 high for 3 edges (too short), then 4 edges (accepted by STABLE)
    for (int n = 0; n < 3; n++) step(4'h2, 1'b0, "short1");
    for (int n = 0; n < 3; n++) step(4'h0, 1'b0, "short1_gap");
    for (int n = 0; n < 8; n++) step(4'h2, 1'b0, "long1");

    // ch2 bounces while ch3 stays high; then all channels toggle together
    for (int n = 0; n < 12; n++) step({1'b1, n[0], 2'b10}, 1'b0, "indep");
    for (int n = 0; n < 10; n++) step(4'h0, 1'b0, "all_fall");
    for (int n = 0; n < 10; n++) step(4'hF, 1'b0, "all_rise");
    for (int n = 0; n < 10; n++) step(4'h0, 1'b0, "settle2");

    // Reset during lockout, then a fresh edge after release
    step(4'h1, 1'b0, "pre_rst");
    step(4'h1, 1'b0, "pre_rst");
    step(4'h1, 1'b1, "mid_hold_rst");
    step(4'h0, 1'b0, "post_rst");
    for (int n = 0; n < 8; n++) step(4'h4, 1'b0, "fresh_edge");

    // Randomized bounce phases with occasional resets
    cur = 4'h4;
    for (int n = 0; n < 1500; n++) begin
      p = ((n / 100) % 3 == 0) ? 40 : (((n / 100) % 3 == 1) ? 10 : 2);
      mask = '0;
      for (int k = 0; k < CH; k++) mask[k] = ($urandom_range(99) < p);
      cur = cur ^ mask;
      step(cur, ($urandom_range(199) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
